// File: rtl/sbus_mem_slave.sv
// Simple-bus memory slave: captures one request, waits LATENCY cycles, issues one memory access.
// Define SBUS_SLAVE_ERR_EN to flag misaligned / illegal-size requests instead of performing them.
module sbus_mem_slave #(
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] data_w,
   output logic        stall,
   output logic [31:0] data_r,
   output logic        error,
   output logic        mem_en,
   output logic [3:0]  mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        cap_we;
   logic [1:0]  cap_size;
   logic [31:0] cap_addr;
   logic [31:0] cap_data;

   logic        sel_we;
   logic [1:0]  sel_size;
   logic [31:0] sel_addr;
   logic [31:0] sel_data;
   logic [3:0]  sel_be;
   logic        sel_err;

   // In IDLE the live bus request is decoded so a zero-latency access can launch
   // straight from capture; afterwards only the captured copy matters.
   always_comb begin
      sel_we   = cap_we;
      sel_size = cap_size;
      sel_addr = cap_addr;
      sel_data = cap_data;
      if (state == IDLE) begin
         sel_we   = we;
         sel_size = size;
         sel_addr = addr;
         sel_data = data_w;
      end
      case (sel_size)
         2'd0:    sel_be = 4'b0001 << sel_addr[1:0];
         2'd1:    sel_be = 4'b0011 << {sel_addr[1], 1'b0};
         default: sel_be = 4'b1111;
      endcase
`ifdef SBUS_SLAVE_ERR_EN
      sel_err = (sel_size == 2'd3)
             || (sel_size == 2'd1 && sel_addr[0])
             || (sel_size == 2'd2 && sel_addr[1:0] != 2'b00);
`else
      sel_err = 1'b0;
`endif
   end

   assign stall = (state == IDLE && en) || state == WAIT || state == ACCESS;

   // Single FSM; memory strobes and error are registered so they line up with ACCESS/DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_size  <= 2'd0;
         cap_addr  <= 32'd0;
         cap_data  <= 32'd0;
         error     <= 1'b0;
         data_r    <= 32'd0;
         mem_en    <= 1'b0;
         mem_we    <= 4'b0000;
         mem_addr  <= 30'd0;
         mem_wdata <= 32'd0;
      end else begin
         mem_en <= 1'b0;
         mem_we <= 4'b0000;
         error  <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  cap_we   <= we;
                  cap_size <= size;
                  cap_addr <= addr;
                  cap_data <= data_w;
                  if (LAT != 4'd0) begin
                     state <= WAIT;
                     cnt   <= LAT;
                  end else if (sel_err) begin
                     state <= DONE;
                     error <= 1'b1;
                  end else begin
                     state     <= ACCESS;
                     mem_en    <= 1'b1;
                     mem_we    <= sel_we ? sel_be : 4'b0000;
                     mem_addr  <= sel_addr[31:2];
                     mem_wdata <= sel_data;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  if (sel_err) begin
                     state <= DONE;
                     error <= 1'b1;
                  end else begin
                     state     <= ACCESS;
                     mem_en    <= 1'b1;
                     mem_we    <= sel_we ? sel_be : 4'b0000;
                     mem_addr  <= sel_addr[31:2];
                     mem_wdata <= sel_data;
                  end
               end
            end
            ACCESS: begin
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
               if (!sel_we && !sel_err)
                  data_r <= mem_rdata;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sbus_mem_slave.sv
// Self-checking bench for sbus_mem_slave: vector table on a LATENCY=2 instance,
// plus hand sequences for zero latency, back-to-back requests and mid-request reset.
module tb_sbus_mem_slave;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en, we;
   logic [1:0]  size;
   logic [31:0] addr, data_w;
   logic        stall, error, mem_en;
   logic [31:0] data_r, mem_wdata, mem_rdata;
   logic [3:0]  mem_we;
   logic [29:0] mem_addr;

   logic        en_z, we_z;
   logic [1:0]  size_z;
   logic [31:0] addr_z, data_w_z;
   logic        stall_z, error_z, mem_en_z;
   logic [31:0] data_r_z, mem_wdata_z, mem_rdata_z;
   logic [3:0]  mem_we_z;
   logic [29:0] mem_addr_z;

   int checks = 0;
   int failures = 0;
   logic loadMem = 1'b1;
   logic [31:0] expDr = 32'h0;

   sbus_mem_slave #(.LATENCY(2)) dut (
      .clk(clk), .rst(rst), .en(en), .we(we), .size(size), .addr(addr),
      .data_w(data_w), .stall(stall), .data_r(data_r), .error(error),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   sbus_mem_slave #(.LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .en(en_z), .we(we_z), .size(size_z), .addr(addr_z),
      .data_w(data_w_z), .stall(stall_z), .data_r(data_r_z), .error(error_z),
      .mem_en(mem_en_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z),
      .mem_wdata(mem_wdata_z), .mem_rdata(mem_rdata_z)
   );

   assign mem_rdata_z = 32'h0;

   // Memory model with one-cycle read latency; preloaded during the first reset only.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (!rst && loadMem) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h40] <= 32'hDEADBEEF;
         mem[8'h80] <= 32'h11223344;
      end else if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  expWe;
      logic        expErr;
      logic [31:0] expRdata;
   } vec_t;

   vec_t vecs[12];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issues one request at the current negedge and follows it through DONE.
   task automatic applyStimulus(input vec_t v, input int idx);
      int done = -1;
      int nmem = 0;
      int memCyc = -1;
      logic [3:0]  gWe = 4'h0;
      logic [29:0] gAddr = 30'h0;
      logic [31:0] gWd = 32'h0;
      logic        gErr = 1'b0;
      string tag;
      tag = $sformatf("vec%0d", idx);
      en = 1'b1; we = v.we; size = v.size; addr = v.addr; data_w = v.wdata;
      #1;
      checkOutput({tag, " stall_c0"}, 32'(stall), 32'h1);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (mem_en) begin
            nmem++; memCyc = cyc; gWe = mem_we; gAddr = mem_addr; gWd = mem_wdata;
         end
         if (cyc == 1) begin
            en = 1'b0; we = ~v.we; size = v.size ^ 2'b11;
            addr = 32'hFFFF_FFFF; data_w = ~v.wdata;
         end
         if (!stall) begin
            done = cyc; gErr = error;
            break;
         end
      end
      checkOutput({tag, " done_cycle"}, 32'(done), v.expErr ? 32'd3 : 32'd4);
      checkOutput({tag, " error"}, 32'(gErr), 32'(v.expErr));
      checkOutput({tag, " mem_en_count"}, 32'(nmem), v.expErr ? 32'd0 : 32'd1);
      if (!v.expErr) begin
         checkOutput({tag, " mem_en_cycle"}, 32'(memCyc), 32'd3);
         checkOutput({tag, " mem_we"}, 32'(gWe), 32'(v.expWe));
         checkOutput({tag, " mem_addr"}, 32'(gAddr), {2'b00, v.addr[31:2]});
         if (v.we) checkOutput({tag, " mem_wdata"}, gWd, v.wdata);
         if (!v.we) expDr = v.expRdata;
      end
      @(negedge clk);
      checkOutput({tag, " data_r"}, data_r, expDr);
      checkOutput({tag, " error_after"}, 32'(error), 32'h0);
   endtask

   initial begin
      int stallLog [0:12];
      int memCycs [0:1];
      logic [29:0] memAddrs [0:1];
      int nm;
      logic [31:0] dr5, dr10;

      vecs[0]  = '{1'b0, 2'd2, 32'h100, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEF};
      vecs[1]  = '{1'b1, 2'd0, 32'h203, 32'hAB000000, 4'b1000, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 2'd1, 32'h011, 32'h00001234, 4'b0011, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 2'd1, 32'h012, 32'h56780000, 4'b1100, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 2'd2, 32'h104, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 2'd2, 32'h104, 32'h0,        4'b0000, 1'b0, 32'hCAFEF00D};
      vecs[6]  = '{1'b0, 2'd0, 32'h201, 32'h0,        4'b0000, 1'b0, 32'hAB223344};
      vecs[7]  = '{1'b0, 2'd2, 32'h102, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEF};
      vecs[8]  = '{1'b1, 2'd3, 32'h108, 32'h01020304, 4'b1111, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 2'd1, 32'h012, 32'h0,        4'b0000, 1'b0, 32'h56781234};
      vecs[10] = '{1'b1, 2'd0, 32'h100, 32'h000000EE, 4'b0001, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 2'd2, 32'h100, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEE};
`ifdef SBUS_SLAVE_ERR_EN
      vecs[2].expErr = 1'b1;
      vecs[7].expErr = 1'b1;
      vecs[8].expErr = 1'b1;
      vecs[9].expRdata = 32'h56780000;
`endif

      rst = 1'b0; en = 1'b0; we = 1'b0; size = 2'd0; addr = 32'h0; data_w = 32'h0;
      en_z = 1'b0; we_z = 1'b0; size_z = 2'd0; addr_z = 32'h0; data_w_z = 32'h0;
      repeat (3) @(negedge clk);
      checkOutput("reset stall", 32'(stall), 32'h0);
      checkOutput("reset error", 32'(error), 32'h0);
      checkOutput("reset mem_en", 32'(mem_en), 32'h0);
      checkOutput("reset mem_we", 32'(mem_we), 32'h0);
      checkOutput("reset data_r", data_r, 32'h0);
      checkOutput("reset stall_z", 32'(stall_z), 32'h0);
      loadMem = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

      // Zero-latency byte write on the second instance.
      en_z = 1'b1; we_z = 1'b1; size_z = 2'd0; addr_z = 32'h203; data_w_z = 32'hAB000000;
      #1;
      checkOutput("z stall_c0", 32'(stall_z), 32'h1);
      @(negedge clk);
      checkOutput("z mem_en_c1", 32'(mem_en_z), 32'h1);
      checkOutput("z mem_we_c1", 32'(mem_we_z), 32'h8);
      checkOutput("z mem_addr_c1", 32'(mem_addr_z), 32'h80);
      checkOutput("z mem_wdata_c1", mem_wdata_z, 32'hAB000000);
      checkOutput("z stall_c1", 32'(stall_z), 32'h1);
      en_z = 1'b0;
      @(negedge clk);
      checkOutput("z stall_c2", 32'(stall_z), 32'h0);
      checkOutput("z mem_en_c2", 32'(mem_en_z), 32'h0);
      checkOutput("z error_c2", 32'(error_z), 32'h0);
      checkOutput("z data_r_c2", data_r_z, 32'h0);
      @(negedge clk);

      // Back-to-back reads with en held; en dropped during the second WAIT.
      nm = 0; dr5 = 32'h0; dr10 = 32'h0;
      memCycs[0] = -1; memCycs[1] = -1; memAddrs[0] = 30'h0; memAddrs[1] = 30'h0;
      en = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h100; data_w = 32'h0;
      #1;
      stallLog[0] = int'(stall);
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         stallLog[cyc] = int'(stall);
         if (mem_en) begin
            if (nm < 2) begin memCycs[nm] = cyc; memAddrs[nm] = mem_addr; end
            nm++;
         end
         if (cyc == 5) dr5 = data_r;
         if (cyc == 10) dr10 = data_r;
         if (cyc == 1) addr = 32'h104;
         if (cyc == 6) en = 1'b0;
      end
      checkOutput("b2b stall_c0", 32'(stallLog[0]), 32'h1);
      checkOutput("b2b stall_c4", 32'(stallLog[4]), 32'h0);
      checkOutput("b2b stall_c5", 32'(stallLog[5]), 32'h1);
      checkOutput("b2b stall_c9", 32'(stallLog[9]), 32'h0);
      checkOutput("b2b stall_c10", 32'(stallLog[10]), 32'h0);
      checkOutput("b2b mem_en_count", 32'(nm), 32'd2);
      checkOutput("b2b first_cycle", 32'(memCycs[0]), 32'd3);
      checkOutput("b2b first_addr", 32'(memAddrs[0]), 32'h40);
      checkOutput("b2b second_cycle", 32'(memCycs[1]), 32'd8);
      checkOutput("b2b second_addr", 32'(memAddrs[1]), 32'h41);
      checkOutput("b2b data_r_c5", dr5, 32'hDEADBEEE);
      checkOutput("b2b data_r_c10", dr10, 32'hCAFEF00D);

      // Reset during WAIT of a write abandons it.
      nm = 0;
      en = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h10C; data_w = 32'h55555555;
      #1;
      checkOutput("rstwait stall_c0", 32'(stall), 32'h1);
      @(negedge clk);
      checkOutput("rstwait stall_c1", 32'(stall), 32'h1);
      rst = 1'b0; en = 1'b0;
      @(negedge clk);
      checkOutput("rstwait stall_c2", 32'(stall), 32'h0);
      checkOutput("rstwait data_r", data_r, 32'h0);
      checkOutput("rstwait error", 32'(error), 32'h0);
      checkOutput("rstwait mem_we", 32'(mem_we), 32'h0);
      if (mem_en) nm++;
      rst = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (mem_en) nm++;
      end
      checkOutput("rstwait mem_en_count", 32'(nm), 32'd0);
      checkOutput("rstwait mem_word", mem[8'h43], 32'h0);
      checkOutput("rstwait stall_idle", 32'(stall), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sbus_mem_slave.md
SBUS_MEM_SLAVE -- requirements
Module: sbus_mem_slave

Interface
REQ-001 Parameter LATENCY, default 2, wait cycles inserted before each memory access, legal range 0..15.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 en  in  1  sbus request valid.
REQ-005 we  in  1  1 = write, 0 = read.
REQ-006 size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-007 addr  in  32  byte address.
REQ-008 data_w  in  32  write data, already lane-aligned by master.
REQ-009 stall  out  1  request not yet complete; master holds request while high.
REQ-010 data_r  out  32  read word at {addr[31:2],2'b00}, unshifted.
REQ-011 error  out  1  misaligned/illegal-size response flag.
REQ-012 mem_en  out  1  memory access strobe.
REQ-013 mem_we  out  4  byte write enables.
REQ-014 mem_addr  out  30  word address.
REQ-015 mem_wdata  out  32  write data to memory.
REQ-016 mem_rdata  in  32  read data, valid one cycle after mem_en.

Function
REQ-017 FSM states IDLE, WAIT, ACCESS, DONE; one transaction in flight.
REQ-018 IDLE with en=1: capture we/size/addr/data_w; next WAIT if LATENCY>0, else ACCESS.
REQ-019 WAIT: counter loaded with LATENCY on entry, decrements per cycle; leave for ACCESS after exactly LATENCY WAIT cycles.
REQ-020 ACCESS: mem_en=1 for exactly one cycle, mem_addr=captured addr[31:2], mem_wdata=captured data_w, mem_we=byte enables if write else 4'b0000; next DONE.
REQ-021 DONE lasts exactly one cycle, then IDLE; new request accepted no earlier than the following IDLE cycle.
REQ-022 stall = (IDLE and en) or WAIT or ACCESS; stall=0 in DONE and in IDLE without en.
REQ-023 Request accepted at cycle 0: stall high cycles 0..LATENCY+1, low at LATENCY+2 (DONE).
REQ-024 Read: data_r register loads mem_rdata at end of DONE; valid from DONE+1, held until next read's DONE; writes and errored requests leave data_r unchanged.
REQ-025 Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<{addr[1],1'b0}; word -> 4'b1111.
REQ-026 Inputs changing or en dropping after capture have no effect; captured request always completes.
REQ-027 mem_en never asserted outside ACCESS.

Reset
REQ-028 rst=0 at a clock edge forces IDLE from any state; stall, error, mem_en, mem_we, data_r, counter all 0.
REQ-029 Reset before ACCESS abandons the request; no memory write issued.
REQ-030 First request accepted in the first cycle with rst=1.

Configuration
REQ-031 Macro SBUS_SLAVE_ERR_EN defined: size=3, half with addr[0]=1, or word with addr[1:0]!=0 is errored; ACCESS skipped (WAIT/IDLE goes straight to DONE), no memory access, error=1 only during DONE.
REQ-032 Macro undefined: no checking; error tied 0; size=3 treated as word; word/half enables ignore offending low address bits (word 4'b1111, half uses addr[1] only).

Verification
REQ-033 LATENCY=2, read addr=0x100, mem[0x40]=0xDEADBEEF: stall 1 cycles 0-3, mem_en only cycle 3, stall 0 cycle 4, data_r=0xDEADBEEF from cycle 5.
REQ-034 LATENCY=0, byte write addr=0x203 data_w=0xAB000000: mem_en cycle 1, mem_we=4'b1000, mem_addr=0x80, stall 0 cycle 2.
REQ-035 ERR_EN defined, word read addr=0x102: mem_en never asserts, error=1 in DONE (cycle LATENCY+1), data_r unchanged.
REQ-036 Back-to-back reads with en held high: second accepted cycle after DONE; en dropped during WAIT still completes first read.
REQ-037 rst=0 during WAIT of a write: next cycle IDLE, stall=0, mem_en never asserted, data_r=0.
REQ-038 ERR_EN undefined, half write addr=0x11 size=1: mem_we=4'b0011, error stays 0.
